axil_copy_master: RTL and testbench

- AXI4-Lite master copy engine that fetches a run of 32-bit words from the XIP read window and writes them to a destination slave.
- It is the initiator side of the AXI4-Lite interface that `xip_engine` serves. Typical use is shadowing boot code from QSPI flash into on-chip RAM.
- Word transfers are strictly sequential: one read, then one write.
- Response errors abort the run and are reported.

---
 rtl/axil_copy_master.sv | 224 ++++++++++++++++++++++
 tb/tb_axil_copy_master.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_copy_master.sv
// axil_copy_master: AXI4-Lite master that copies a run of 32-bit words from src to dst,
// one read then one write per word. Define COPY_VERIFY_EN to read back and compare each word.
module axil_copy_master #(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_words_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [LEN_W-1:0] words_done_o,
    output logic [31:0]      araddr_o,
    output logic             arvalid_o,
    input  logic             arready_i,
    input  logic [31:0]      rdata_i,
    input  logic [1:0]       rresp_i,
    input  logic             rvalid_i,
    output logic             rready_o,
    output logic [31:0]      awaddr_o,
    output logic             awvalid_o,
    input  logic             awready_i,
    output logic [31:0]      wdata_o,
    output logic [3:0]       wstrb_o,
    output logic             wvalid_o,
    input  logic             wready_i,
    input  logic [1:0]       bresp_i,
    input  logic             bvalid_i,
    output logic             bready_o
);

`ifdef COPY_VERIFY_EN
    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_W, S_B, S_DONE, S_RB_AR, S_RB_R} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_W, S_B, S_DONE} state_t;
`endif

    state_t           r_state;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [31:0]      r_data;
    logic [31:0]      r_araddr;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_words;
    logic             r_err;
    logic             r_busy;
    logic             r_done;
    logic             r_arvalid;
    logic             r_rready;
    logic             r_awvalid;
    logic             r_wvalid;
    logic             r_bready;

    logic [31:0] w_src_al;
    logic [31:0] w_dst_al;
    logic [31:0] w_src_next;
    logic [31:0] w_dst_next;
    logic        w_aw_done;
    logic        w_w_done;
    logic        w_last;

    assign w_src_al   = {src_addr_i[31:2], 2'b00};
    assign w_dst_al   = {dst_addr_i[31:2], 2'b00};
    assign w_src_next = r_src + 32'd4;
    assign w_dst_next = r_dst + 32'd4;
    // A channel counts as done once its valid has dropped or is being accepted this cycle
    assign w_aw_done  = ~r_awvalid | awready_i;
    assign w_w_done   = ~r_wvalid | wready_i;
    assign w_last     = (r_words + LEN_W'(1)) == r_len;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_src     <= '0;
            r_dst     <= '0;
            r_data    <= '0;
            r_araddr  <= '0;
            r_len     <= '0;
            r_words   <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_src   <= w_src_al;
                        r_dst   <= w_dst_al;
                        r_len   <= len_words_i;
                        r_err   <= 1'b0;
                        r_words <= '0;
                        r_busy  <= 1'b1;
                        if (len_words_i == '0) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_araddr  <= w_src_al;
                            r_state   <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    if (arready_i) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_R;
                    end
                end
                S_R: begin
                    if (rvalid_i) begin
                        r_rready <= 1'b0;
                        r_data   <= rdata_i;
                        if (rresp_i != 2'b00) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_W;
                        end
                    end
                end
                S_W: begin
                    if (awready_i) r_awvalid <= 1'b0;
                    if (wready_i)  r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= S_B;
                    end
                end
                S_B: begin
                    if (bvalid_i) begin
                        r_bready <= 1'b0;
                        if (bresp_i != 2'b00) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
`ifdef COPY_VERIFY_EN
                            r_arvalid <= 1'b1;
                            r_araddr  <= r_dst;
                            r_state   <= S_RB_AR;
`else
                            r_words <= r_words + LEN_W'(1);
                            r_src   <= w_src_next;
                            r_dst   <= w_dst_next;
                            if (w_last) begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_arvalid <= 1'b1;
                                r_araddr  <= w_src_next;
                                r_state   <= S_AR;
                            end
`endif
                        end
                    end
                end
`ifdef COPY_VERIFY_EN
                S_RB_AR: begin
                    if (arready_i) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RB_R;
                    end
                end
                S_RB_R: begin
                    if (rvalid_i) begin
                        r_rready <= 1'b0;
                        if ((rresp_i != 2'b00) || (rdata_i != r_data)) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_words <= r_words + LEN_W'(1);
                            r_src   <= w_src_next;
                            r_dst   <= w_dst_next;
                            if (w_last) begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_arvalid <= 1'b1;
                                r_araddr  <= w_src_next;
                                r_state   <= S_AR;
                            end
                        end
                    end
                end
`endif
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign err_o        = r_err;
    assign words_done_o = r_words;
    assign araddr_o     = r_araddr;
    assign arvalid_o    = r_arvalid;
    assign rready_o     = r_rready;
    assign awaddr_o     = r_dst;
    assign awvalid_o    = r_awvalid;
    assign wdata_o      = r_data;
    assign wstrb_o      = {4{r_wvalid}};
    assign wvalid_o     = r_wvalid;
    assign bready_o     = r_bready;

endmodule

// File: tb/tb_axil_copy_master.sv
// tb_axil_copy_master: randomized AXI4-Lite source/RAM slaves around axil_copy_master,
// checked against a word-level copy model. Honours COPY_VERIFY_EN when defined.
module tb_axil_copy_master;

`ifdef COPY_VERIFY_EN
    localparam bit VERIFY   = 1'b1;
    localparam int PER_WORD = 6;
`else
    localparam bit VERIFY   = 1'b0;
    localparam int PER_WORD = 4;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] src_addr_i = '0;
    logic [31:0] dst_addr_i = '0;
    logic [15:0] len_words_i = '0;
    logic        busy_o, done_o, err_o;
    logic [15:0] words_done_o;
    logic [31:0] araddr_o, awaddr_o, wdata_o;
    logic        arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o;
    logic [3:0]  wstrb_o;
    logic        arready_i = 1'b0, rvalid_i = 1'b0, awready_i = 1'b0, wready_i = 1'b0, bvalid_i = 1'b0;
    logic [31:0] rdata_i = '0;
    logic [1:0]  rresp_i = '0, bresp_i = '0;

    axil_copy_master #(.LEN_W(16)) dut (
        .clk(clk), .reset(reset), .start_i(start_i),
        .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_words_i(len_words_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .words_done_o(words_done_o),
        .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Slave knobs
    int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [31:0] rerr_addr = 32'h1, berr_addr = 32'h1, corrupt_addr = 32'h1;
    bit          erased = 1'b0;

    logic [31:0] ram [logic [31:0]];
    logic [31:0] obs_ar[$], obs_aw[$], obs_wd[$];

    function automatic logic [31:0] src_data(input logic [31:0] a);
        return erased ? 32'hFFFF_FFFF : ({a[15:0], ~a[15:0]} ^ 32'h3C3C_A5A5);
    endfunction

    // Slave state; decisions are made on the falling edge and take effect at the next rising edge
    bit          ar_got = 0, r_hs = 0, aw_got = 0, w_got = 0, b_hs = 0;
    int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    logic [31:0] ar_addr = '0, aw_addr = '0, w_data = '0;

    always @(negedge clk) begin
        if (reset) begin
            arready_i = 0; rvalid_i = 0; awready_i = 0; wready_i = 0; bvalid_i = 0;
            ar_got = 0; r_hs = 0; aw_got = 0; w_got = 0; b_hs = 0;
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        end else begin
            if (r_hs) begin rvalid_i = 0; ar_got = 0; r_hs = 0; end
            if (ar_got && !rvalid_i) begin
                if (r_cnt >= r_dly) begin
                    rvalid_i = 1;
                    rdata_i  = ram.exists(ar_addr) ? ram[ar_addr] : src_data(ar_addr);
                    rresp_i  = (ar_addr == rerr_addr) ? 2'b10 : 2'b00;
                end else r_cnt++;
            end
            r_hs = rvalid_i && rready_o;
            arready_i = 0;
            if (!ar_got && arvalid_o) begin
                if (ar_cnt >= ar_dly) begin
                    arready_i = 1; ar_got = 1; ar_addr = araddr_o;
                    obs_ar.push_back(araddr_o); ar_cnt = 0; r_cnt = 0;
                end else ar_cnt++;
            end

            if (b_hs) begin bvalid_i = 0; aw_got = 0; w_got = 0; b_hs = 0; end
            if (aw_got && w_got && !bvalid_i) begin
                if (b_cnt >= b_dly) begin
                    bvalid_i = 1;
                    bresp_i  = (aw_addr == berr_addr) ? 2'b10 : 2'b00;
                    if (bresp_i == 2'b00)
                        ram[aw_addr] = (aw_addr == corrupt_addr) ? (w_data ^ 32'h1) : w_data;
                end else b_cnt++;
            end
            b_hs = bvalid_i && bready_o;
            awready_i = 0;
            if (!aw_got && awvalid_o) begin
                if (aw_cnt >= aw_dly) begin
                    awready_i = 1; aw_got = 1; aw_addr = awaddr_o;
                    obs_aw.push_back(awaddr_o); aw_cnt = 0; b_cnt = 0;
                end else aw_cnt++;
            end
            wready_i = 0;
            if (!w_got && wvalid_o) begin
                if (w_cnt >= w_dly) begin
                    wready_i = 1; w_got = 1; w_data = wdata_o;
                    obs_wd.push_back(wdata_o); w_cnt = 0; b_cnt = 0;
                    check("wstrb", {28'h0, wstrb_o}, 32'hF);
                end else w_cnt++;
            end
        end
    end

    logic [31:0] cyc = '0, done_cyc = '0;
    int          done_cnt = 0;
    bit          any_ar = 0, any_aw = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done_o) begin done_cnt++; done_cyc = cyc; end
        if (arvalid_o) any_ar = 1;
        if (awvalid_o) any_aw = 1;
    end

    // Word-level model of one copy run
    logic [31:0] exp_ar[$], exp_aw[$], exp_wd[$];
    logic [31:0] exp_ram [logic [31:0]];
    bit          exp_err;
    int          exp_words;

    task automatic model(input logic [31:0] s0, input logic [31:0] d0, input int len);
        logic [31:0] s, d, data, stored;
        s = s0; d = d0; exp_err = 0; exp_words = 0;
        exp_ar.delete(); exp_aw.delete(); exp_wd.delete(); exp_ram.delete();
        for (int i = 0; i < len; i++) begin
            exp_ar.push_back(s);
            if (s == rerr_addr) begin exp_err = 1; break; end
            data = src_data(s);
            exp_aw.push_back(d); exp_wd.push_back(data);
            if (d == berr_addr) begin exp_err = 1; break; end
            stored = (d == corrupt_addr) ? (data ^ 32'h1) : data;
            exp_ram[d] = stored;
            if (VERIFY) begin
                exp_ar.push_back(d);
                if (d == rerr_addr || stored != data) begin exp_err = 1; break; end
            end
            exp_words++;
            s = s + 32'd4; d = d + 32'd4;
        end
    endtask

    task automatic set_slave(input int a, input int r, input int aw, input int w, input int b);
        ar_dly = a; r_dly = r; aw_dly = aw; w_dly = w; b_dly = b;
        rerr_addr = 32'h1; berr_addr = 32'h1; corrupt_addr = 32'h1;
    endtask

    task automatic run_copy(input string name, input logic [31:0] src, input logic [31:0] dst, input int len);
        logic [31:0] e0;
        bit          timed;
        int          k;
        timed = (ar_dly == 0 && r_dly == 0 && aw_dly == 0 && w_dly == 0 && b_dly == 0);
        model({src[31:2], 2'b00}, {dst[31:2], 2'b00}, len);
        timed = timed && !exp_err;
        @(negedge clk); #1;
        ram.delete(); obs_ar.delete(); obs_aw.delete(); obs_wd.delete();
        done_cnt = 0; any_ar = 0; any_aw = 0;
        start_i = 1; src_addr_i = src; dst_addr_i = dst; len_words_i = 16'(len);
        e0 = cyc + 1;
        @(negedge clk); #1;
        start_i = 0;
        check({name, "_busy_start"}, busy_o, 1);
        check({name, "_arvalid_start"}, arvalid_o, (len != 0));
        k = 0;
        while (done_cnt == 0 && k < 3000) begin @(negedge clk); k++; end
        check({name, "_done_seen"}, (done_cnt != 0), 1);
        repeat (3) @(negedge clk);
        #1;
        check({name, "_done_pulses"}, done_cnt, 1);
        check({name, "_busy_end"}, busy_o, 0);
        check({name, "_err"}, err_o, exp_err);
        check({name, "_words"}, words_done_o, exp_words);
        if (timed) check({name, "_done_cycle"}, done_cyc, e0 + PER_WORD * len);
        check({name, "_n_ar"}, obs_ar.size(), exp_ar.size());
        for (int i = 0; i < obs_ar.size() && i < exp_ar.size(); i++)
            check($sformatf("%s_araddr%0d", name, i), obs_ar[i], exp_ar[i]);
        check({name, "_n_aw"}, obs_aw.size(), exp_aw.size());
        for (int i = 0; i < obs_aw.size() && i < exp_aw.size(); i++)
            check($sformatf("%s_awaddr%0d", name, i), obs_aw[i], exp_aw[i]);
        check({name, "_n_w"}, obs_wd.size(), exp_wd.size());
        for (int i = 0; i < obs_wd.size() && i < exp_wd.size(); i++)
            check($sformatf("%s_wdata%0d", name, i), obs_wd[i], exp_wd[i]);
        check({name, "_ram_n"}, ram.num(), exp_ram.num());
        foreach (exp_ram[a])
            check($sformatf("%s_ram%h", name, a), ram.exists(a) ? ram[a] : ~exp_ram[a], exp_ram[a]);
    endtask

    initial begin
        int          len, k;
        logic [31:0] s, d;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valids", {arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o}, 0);
        check("rst_status", {busy_o, done_o, err_o}, 0);
        check("rst_words", words_done_o, 0);
        check("rst_addr", araddr_o | awaddr_o | wdata_o, 0);
        check("rst_wstrb", wstrb_o, 0);
        reset = 0;

        set_slave(0, 0, 0, 0, 0);
        erased = 1;
        run_copy("erased", 32'h0, 32'h100, 4);
        erased = 0;

        run_copy("len0", 32'h40, 32'h8000_0000, 0);
        check("len0_no_ar", any_ar, 0);
        check("len0_no_aw", any_aw, 0);

        set_slave(0, 0, 3, 0, 0);
        run_copy("aw_slow", 32'h200, 32'h8000_0200, 3);
        set_slave(0, 0, 0, 3, 0);
        run_copy("w_slow", 32'h300, 32'h8000_0300, 3);

        set_slave(0, 0, 0, 0, 0);
        rerr_addr = 32'h404;
        run_copy("rerr", 32'h400, 32'h8000_0400, 5);

        set_slave(0, 0, 0, 0, 0);
        berr_addr = 32'h8000_0508;
        run_copy("berr", 32'h500, 32'h8000_0500, 4);

        set_slave(0, 0, 0, 0, 0);
        run_copy("wrap", 32'hFFFF_FFFE, 32'h8000_0600, 2);

        // Reset while a write is stalled in W
        set_slave(0, 0, 6, 6, 0);
        @(negedge clk); #1;
        start_i = 1; src_addr_i = 32'h700; dst_addr_i = 32'h8000_0700; len_words_i = 16'd3;
        @(negedge clk); #1;
        start_i = 0;
        k = 0;
        while (!awvalid_o && k < 200) begin @(negedge clk); k++; end
        check("rst_w_awvalid_seen", awvalid_o, 1);
        #1 reset = 1;
        @(negedge clk); #1;
        check("rst_w_valids", {arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o}, 0);
        check("rst_w_busy", busy_o, 0);
        reset = 0;
        set_slave(0, 0, 0, 0, 0);
        run_copy("after_rst", 32'h800, 32'h8000_0800, 2);

`ifdef COPY_VERIFY_EN
        set_slave(0, 0, 0, 0, 0);
        corrupt_addr = 32'h8000_0904;
        run_copy("corrupt", 32'h900, 32'h8000_0900, 3);
`endif

        for (int it = 0; it < 16; it++) begin
            set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) set_slave(0, 0, 0, 0, 0);
            len = $urandom_range(0, 6);
            s = 32'h1000 + 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(0, 3));
            d = 32'h8000_1000 + 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(0, 3));
            if (len > 0) begin
                k = $urandom_range(0, len - 1);
                case ($urandom_range(0, 3))
                    0: rerr_addr = {s[31:2], 2'b00} + 32'(k) * 4;
                    1: berr_addr = {d[31:2], 2'b00} + 32'(k) * 4;
                    2: if (VERIFY) corrupt_addr = {d[31:2], 2'b00} + 32'(k) * 4;
                    default: ;
                endcase
            end
            run_copy($sformatf("rnd%0d", it), s, d, len);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
